// File: rtl/gat_aggregator.sv
`default_nettype none
// ============================================================================
// gat_aggregator : alpha-weighted neighbour feature aggregation, scaled and
// saturated per subgraph.  Optional define GAT_AGG_RELU_EN clamps negatives.
// Revision 1.0
// ============================================================================
module gat_aggregator #(
  parameter int MAX_NODES        = 16,
  parameter int NUM_NODE_WIDTH   = $clog2(MAX_NODES) + 1,
  parameter int ALPHA_DATA_WIDTH = 16,
  parameter int ALPHA_FRAC       = 8,
  parameter int FEAT_DATA_WIDTH  = 16,
  parameter int NUM_FEATURES     = 16,
  parameter int OUT_DATA_WIDTH   = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    sm_ready_i,
  input  logic [MAX_NODES*ALPHA_DATA_WIDTH-1:0]   alpha_i,
  input  logic [NUM_NODE_WIDTH-1:0]               sm_num_of_nodes_i,
  output logic                                    feat_rd_en_o,
  output logic [NUM_NODE_WIDTH-1:0]               feat_rd_addr_o,
  input  logic [NUM_FEATURES*FEAT_DATA_WIDTH-1:0] feat_rd_data_i,
  output logic                                    feat_next_o,
  output logic                                    agg_valid_o,
  input  logic                                    agg_ready_i,
  output logic [NUM_FEATURES*OUT_DATA_WIDTH-1:0]  agg_data_o,
  output logic                                    agg_overflow_o
);

  localparam int PROD_W      = ALPHA_DATA_WIDTH + FEAT_DATA_WIDTH + 1;
  localparam int ACC_W       = PROD_W + $clog2(MAX_NODES);
  localparam int ALPHA_VEC_W = MAX_NODES * ALPHA_DATA_WIDTH;
  localparam int OUT_VEC_W   = NUM_FEATURES * OUT_DATA_WIDTH;
  localparam logic [NUM_NODE_WIDTH-1:0] ONE   = NUM_NODE_WIDTH'(1);
  localparam logic [NUM_NODE_WIDTH-1:0] N_MAX = NUM_NODE_WIDTH'(MAX_NODES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [ALPHA_VEC_W-1:0]      alpha_q, alpha_d;
  logic [NUM_NODE_WIDTH-1:0]   n_q, n_d;
  logic                        pend_valid_q, pend_valid_d;
  logic [ALPHA_VEC_W-1:0]      pend_alpha_q, pend_alpha_d;
  logic [NUM_NODE_WIDTH-1:0]   pend_n_q, pend_n_d;
  logic                        rd_en_q, rd_en_d;
  logic [NUM_NODE_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                        acc_en_q, acc_en_d;
  logic [NUM_NODE_WIDTH-1:0]   acc_idx_q, acc_idx_d;
  logic signed [ACC_W-1:0]     acc_q [NUM_FEATURES];
  logic signed [ACC_W-1:0]     acc_d [NUM_FEATURES];
  logic                        valid_q, valid_d;
  logic [OUT_VEC_W-1:0]        data_q, data_d;
  logic                        next_q, next_d;
  logic                        ovf_q, ovf_d;

  logic                        hs;
  logic                        start_new;
  logic                        start_pend;
  logic [ALPHA_VEC_W-1:0]      alpha_sel;
  logic [NUM_NODE_WIDTH-1:0]   n_sel;

  // Unsigned alpha times signed Wh, sign-extended to accumulator width.
  function automatic logic signed [ACC_W-1:0] weighted(
    input logic [ALPHA_DATA_WIDTH-1:0] a,
    input logic [FEAT_DATA_WIDTH-1:0]  w
  );
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] prod;
    a_ext = $signed({{(PROD_W-ALPHA_DATA_WIDTH){1'b0}}, a});
    w_ext = $signed({{(PROD_W-FEAT_DATA_WIDTH){w[FEAT_DATA_WIDTH-1]}}, w});
    prod  = a_ext * w_ext;
    return $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
  endfunction

  function automatic logic [OUT_DATA_WIDTH-1:0] scale_sat(
    input logic signed [ACC_W-1:0] acc
  );
    logic signed [ACC_W-1:0]    sh;
    logic [OUT_DATA_WIDTH-1:0]  res;
    sh = acc >>> ALPHA_FRAC;
    if ((&sh[ACC_W-1:OUT_DATA_WIDTH-1]) || !(|sh[ACC_W-1:OUT_DATA_WIDTH-1]))
      res = sh[OUT_DATA_WIDTH-1:0];
    else if (sh[ACC_W-1])
      res = {1'b1, {(OUT_DATA_WIDTH-1){1'b0}}};
    else
      res = {1'b0, {(OUT_DATA_WIDTH-1){1'b1}}};
`ifdef GAT_AGG_RELU_EN
    if (res[OUT_DATA_WIDTH-1])
      res = '0;
`endif
    return res;
  endfunction

  always_comb begin
    state_d      = state_q;
    alpha_d      = alpha_q;
    n_d          = n_q;
    pend_valid_d = pend_valid_q;
    pend_alpha_d = pend_alpha_q;
    pend_n_d     = pend_n_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = '0;
    acc_en_d     = rd_en_q;
    acc_idx_d    = rd_addr_q;
    valid_d      = valid_q;
    data_d       = data_q;
    next_d       = 1'b0;
    ovf_d        = ovf_q;
    start_new    = 1'b0;
    start_pend   = 1'b0;
    alpha_sel    = alpha_i;
    n_sel        = sm_num_of_nodes_i;
    hs           = (state_q == S_OUT) && valid_q && agg_ready_i;

    // Read data arrives one cycle after its strobe; acc_en/acc_idx track that.
    for (int f = 0; f < NUM_FEATURES; f++) begin
      acc_d[f] = acc_q[f];
      if (acc_en_q)
        acc_d[f] = acc_q[f] + weighted(
          alpha_q[acc_idx_q*ALPHA_DATA_WIDTH +: ALPHA_DATA_WIDTH],
          feat_rd_data_i[f*FEAT_DATA_WIDTH +: FEAT_DATA_WIDTH]);
    end

    case (state_q)
      S_IDLE: begin
        if (sm_ready_i)
          start_new = 1'b1;
      end
      S_ACC: begin
        if (rd_addr_q == n_q - ONE) begin
          state_d = S_DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ONE;
        end
      end
      S_DRAIN: begin
        state_d = S_OUT;
        valid_d = 1'b1;
        for (int f = 0; f < NUM_FEATURES; f++)
          data_d[f*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = scale_sat(acc_d[f]);
      end
      S_OUT: begin
        if (hs) begin
          next_d  = 1'b1;
          valid_d = 1'b0;
          if (pend_valid_q)
            start_pend = 1'b1;
          else if (sm_ready_i)
            start_new = 1'b1;
          else
            state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pulse not consumed directly goes to the pending slot, which is freed
    // in the same cycle when its entry is promoted.
    if (sm_ready_i && !start_new) begin
      if (start_pend || !pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_alpha_d = alpha_i;
        pend_n_d     = sm_num_of_nodes_i;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (start_pend) begin
      pend_valid_d = 1'b0;
    end

    if (start_pend) begin
      alpha_sel = pend_alpha_q;
      n_sel     = pend_n_q;
    end
    if (n_sel > N_MAX)
      n_sel = N_MAX;

    if (start_new || start_pend) begin
      alpha_d = alpha_sel;
      n_d     = n_sel;
      for (int f = 0; f < NUM_FEATURES; f++)
        acc_d[f] = '0;
      if (n_sel == '0) begin
        state_d = S_OUT;
        valid_d = 1'b1;
        data_d  = '0;
      end else begin
        state_d   = S_ACC;
        rd_en_d   = 1'b1;
        rd_addr_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      alpha_q      <= '0;
      n_q          <= '0;
      pend_valid_q <= 1'b0;
      pend_alpha_q <= '0;
      pend_n_q     <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      acc_en_q     <= 1'b0;
      acc_idx_q    <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      next_q       <= 1'b0;
      ovf_q        <= 1'b0;
      for (int f = 0; f < NUM_FEATURES; f++)
        acc_q[f] <= '0;
    end else begin
      state_q      <= state_d;
      alpha_q      <= alpha_d;
      n_q          <= n_d;
      pend_valid_q <= pend_valid_d;
      pend_alpha_q <= pend_alpha_d;
      pend_n_q     <= pend_n_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      acc_en_q     <= acc_en_d;
      acc_idx_q    <= acc_idx_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      next_q       <= next_d;
      ovf_q        <= ovf_d;
      for (int f = 0; f < NUM_FEATURES; f++)
        acc_q[f] <= acc_d[f];
    end
  end

  assign feat_rd_en_o   = rd_en_q;
  assign feat_rd_addr_o = rd_addr_q;
  assign feat_next_o    = next_q;
  assign agg_valid_o    = valid_q;
  assign agg_data_o     = data_q;
  assign agg_overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: doc/gat_aggregator.md
# gat_aggregator

Weighted neighbour aggregation stage directly downstream of the softmax. On each softmax completion pulse it captures the attention coefficients (alpha) and the subgraph size. It then streams the neighbours' transformed feature vectors (Wh) from the feature buffer and accumulates out[f] = Σ_j alpha[j]·Wh[j][f]. It emits one scaled, saturated feature vector per subgraph over a valid/ready handshake.

## Interface
- MAX_NODES, 16, max neighbours per subgraph
- NUM_NODE_WIDTH, $clog2(MAX_NODES)+1, width of node counts and indices
- ALPHA_DATA_WIDTH, 16, unsigned alpha width
- ALPHA_FRAC, 8, fractional bits of alpha
- FEAT_DATA_WIDTH, 16, signed Wh element width
- NUM_FEATURES, 16, elements per feature vector
- OUT_DATA_WIDTH, 16, signed output element width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sm_ready_i  in  1  one-cycle pulse: alpha_i and sm_num_of_nodes_i are valid
- alpha_i  in  MAX_NODES×ALPHA_DATA_WIDTH  coefficients
- sm_num_of_nodes_i  in  NUM_NODE_WIDTH  subgraph size n (0..MAX_NODES)
- feat_rd_en_o  out  1  feature buffer read strobe
- feat_rd_addr_o  out  NUM_NODE_WIDTH  neighbour index j within the current subgraph
- feat_rd_data_i  in  NUM_FEATURES×FEAT_DATA_WIDTH  Wh[j]; valid 1 cycle after the strobe
- feat_next_o  out  1  pulse: feature buffer advances to the next subgraph
- agg_valid_o  out  1  result valid
- agg_ready_i  in  1  consumer ready
- agg_data_o  out  NUM_FEATURES×OUT_DATA_WIDTH  aggregated vector
- agg_overflow_o  out  1  sticky: a pulse was dropped

## Operation
- States:
  - IDLE
  - ACC: issues reads
  - DRAIN: last read data in flight
  - OUT: holds the result
- IDLE + sm_ready_i:
  - Latch alpha and n into the active registers. Clear the accumulators.
  - Go to ACC. If n=0, go straight to OUT.
- ACC:
  - Read counter runs 0..n-1, one read per cycle. feat_rd_en_o=1 and feat_rd_addr_o=counter.
  - After index n-1 is issued, go to DRAIN.
- Accumulation runs in ACC and DRAIN. In the cycle after each read, every feature f adds alpha[j]·Wh[j][f].
  - alpha is zero-extended; the product is signed, ALPHA_DATA_WIDTH+FEAT_DATA_WIDTH+1 bits.
  - Accumulator width is product width + $clog2(MAX_NODES).
- DRAIN → OUT after the last accumulate.
- OUT output:
  - Each element is the accumulator arithmetically shifted right by ALPHA_FRAC (truncation toward −∞).
  - It is then saturated to the signed OUT_DATA_WIDTH range.
- OUT, valid && ready:
  - Pulse feat_next_o for one cycle.
  - If the pending slot is full: move pending into active, clear the accumulators, go to ACC (or OUT if n=0).
  - Otherwise go to IDLE.
- Pulse rules outside IDLE:
  - sm_ready_i outside IDLE with the pending slot empty: store it in pending.
  - Pending slot full: drop the pulse and set agg_overflow_o. Only reset clears it.
- Pulse in the same cycle as the OUT handshake, pending empty: latch it directly into active (treated as IDLE capture).
- Pulse in the same cycle as the OUT handshake, pending full: the pending entry is promoted and the new pulse goes into the freed pending slot. Nothing is dropped.

## Timing
- Reset values: all outputs 0, state IDLE, pending empty, accumulators 0.
- Latency:
  - sm_ready_i high in cycle 0 → addr 0 in cycle 1, addr n-1 in cycle n.
  - DRAIN in cycle n+1; agg_valid_o=1 from cycle n+2.
  - n=0: agg_valid_o in cycle 1.
- agg_valid_o and agg_data_o stay stable until the handshake; valid never drops without ready.
- After a handshake with pending full, the next ACC read starts the following cycle.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight read data is ignored.
- feat_rd_en_o is high exactly n cycles per subgraph. feat_next_o pulses once per subgraph.

## Configuration
- GAT_AGG_RELU_EN defined: negative saturated results are clamped to 0 (ReLU on output).
- Undefined: signed results pass unchanged.

## Test plan
- Basic average:
  - Stimulus: n=4, all alpha=64 (0.25), Wh[j][f]=4(j+1).
  - Response: every element 10, agg_valid_o rises in cycle 6, four reads at addr 0..3, one feat_next_o.
- Negative value:
  - Stimulus: n=1, alpha=256 (1.0), Wh[0][*]=-5.
  - Response: output -5 without GAT_AGG_RELU_EN, 0 with it.
- Saturation:
  - Stimulus: n=2, alpha=256, Wh=30000.
  - Response: output 32767 in every element.
- Backpressure and overflow:
  - Stimulus: agg_ready_i low for 20 cycles, three pulses during ACC/OUT.
  - Response: two results delivered in order, third dropped, agg_overflow_o=1.
- Empty subgraph:
  - Stimulus: n=0.
  - Response: no reads, zero vector with agg_valid_o in cycle 1.
- Reset mid-ACC:
  - Stimulus: assert rst_n=0 at cycle 3 of an n=8 run.
  - Response: all outputs 0 immediately; a new pulse after release runs normally.
